// File: rtl/sdram_port_arbiter.sv
// ---------------------------------------------------------------------------
// sdram_port_arbiter
//   Shares one SDRAM controller port (valid/ready, 32-bit word) among
//   NUM_PORTS requesters. One request is granted at a time; its payload is
//   registered at grant and held stable for the whole controller access.
//   Read data and a one-cycle, one-hot ready pulse go back to the winner.
//
//   Optional feature macro: SDRAM_ARB_ROUND_ROBIN_EN
//     defined   : round-robin arbitration starting at rr_ptr
//     undefined : fixed priority, port 0 highest
//
// Parameters
//   NUM_PORTS   requester count, 2..4
//   ADDR_WIDTH  byte address width of the controller addr port
//
// Ports
//   clk        system clock (shared with the SDRAM controller)
//   reset      synchronous reset, active-high
//   req_valid  per-port request
//   req_addr   port p at [p*ADDR_WIDTH +: ADDR_WIDTH]
//   req_din    port p write data at [p*32 +: 32]
//   req_wmask  port p byte enables at [p*4 +: 4]; 0 = read
//   req_ready  one-cycle one-hot completion pulse
//   req_dout   read data, valid while req_ready pulses
//   grant_idx  current/last granted port
//   mem_valid  controller valid
//   mem_addr   controller address
//   mem_din    controller write data
//   mem_wmask  controller byte enables
//   mem_dout   controller read data
//   mem_ready  controller ready (high during init, then 1-cycle pulses)
// ---------------------------------------------------------------------------
module sdram_port_arbiter #(
    parameter int unsigned NUM_PORTS  = 3,
    parameter int unsigned ADDR_WIDTH = 25
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_PORTS-1:0]             req_valid,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_PORTS*32-1:0]          req_din,
    input  logic [NUM_PORTS*4-1:0]           req_wmask,
    output logic [NUM_PORTS-1:0]             req_ready,
    output logic [31:0]                      req_dout,
    output logic [1:0]                       grant_idx,
    output logic                             mem_valid,
    output logic [ADDR_WIDTH-1:0]            mem_addr,
    output logic [31:0]                      mem_din,
    output logic [3:0]                       mem_wmask,
    input  logic [31:0]                      mem_dout,
    input  logic                             mem_ready
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned MASK_W = 4;
    localparam int unsigned IDX_W  = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                 state;
    state_t                 state_nxt;

    logic [IDX_W-1:0]       win_idx;
    logic [ADDR_WIDTH-1:0]  sel_addr;
    logic [DATA_W-1:0]      sel_din;
    logic [MASK_W-1:0]      sel_wmask;

    logic [NUM_PORTS-1:0]   req_ready_nxt;
    logic [DATA_W-1:0]      req_dout_nxt;
    logic [IDX_W-1:0]       grant_idx_nxt;
    logic                   mem_valid_nxt;
    logic [ADDR_WIDTH-1:0]  mem_addr_nxt;
    logic [DATA_W-1:0]      mem_din_nxt;
    logic [MASK_W-1:0]      mem_wmask_nxt;

`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0]       rr_ptr;
    logic [IDX_W-1:0]       rr_ptr_nxt;

    // Winner: valid port with the smallest circular distance from rr_ptr.
    always_comb begin
        int unsigned best_dist;
        int unsigned dist;
        win_idx   = '0;
        best_dist = NUM_PORTS;
        dist      = 0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            dist = (i + NUM_PORTS - 32'(rr_ptr)) % NUM_PORTS;
            if (req_valid[i] && (dist < best_dist)) begin
                best_dist = dist;
                win_idx   = IDX_W'(i);
            end
        end
    end
`else
    // Winner: lowest-index valid port.
    always_comb begin
        logic found;
        win_idx = '0;
        found   = 1'b0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (req_valid[i] && !found) begin
                found   = 1'b1;
                win_idx = IDX_W'(i);
            end
        end
    end
`endif

    // Payload of the current winner.
    always_comb begin
        sel_addr  = '0;
        sel_din   = '0;
        sel_wmask = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (win_idx == IDX_W'(i)) begin
                sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_din   = req_din[i*DATA_W +: DATA_W];
                sel_wmask = req_wmask[i*MASK_W +: MASK_W];
            end
        end
    end

    // Next state and next register values for all outputs.
    always_comb begin
        state_nxt     = state;
        req_ready_nxt = '0;
        req_dout_nxt  = req_dout;
        grant_idx_nxt = grant_idx;
        mem_valid_nxt = mem_valid;
        mem_addr_nxt  = mem_addr;
        mem_din_nxt   = mem_din;
        mem_wmask_nxt = mem_wmask;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
        rr_ptr_nxt    = rr_ptr;
`endif
        case (state)
            IDLE: begin
                if (|req_valid) begin
                    state_nxt     = ISSUE;
                    mem_valid_nxt = 1'b1;
                    mem_addr_nxt  = sel_addr;
                    mem_din_nxt   = sel_din;
                    mem_wmask_nxt = sel_wmask;
                    grant_idx_nxt = win_idx;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
                    rr_ptr_nxt    = (32'(win_idx) == NUM_PORTS - 1) ? '0
                                                                    : win_idx + IDX_W'(1);
`endif
                end
            end
            // A high mem_ready here is left over from init or the previous
            // completion; wait for it to drop before trusting the next pulse.
            ISSUE: begin
                if (!mem_ready) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (mem_ready) begin
                    state_nxt     = DONE;
                    req_dout_nxt  = mem_dout;
                    mem_valid_nxt = 1'b0;
                    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                        req_ready_nxt[i] = (grant_idx == IDX_W'(i));
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            req_ready <= '0;
            req_dout  <= '0;
            grant_idx <= '0;
            mem_valid <= 1'b0;
            mem_addr  <= '0;
            mem_din   <= '0;
            mem_wmask <= '0;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
            rr_ptr    <= '0;
`endif
        end else begin
            state     <= state_nxt;
            req_ready <= req_ready_nxt;
            req_dout  <= req_dout_nxt;
            grant_idx <= grant_idx_nxt;
            mem_valid <= mem_valid_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_din   <= mem_din_nxt;
            mem_wmask <= mem_wmask_nxt;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
            rr_ptr    <= rr_ptr_nxt;
`endif
        end
    end

endmodule
